// File: rtl/transmitter.sv
// Serial frame transmitter: bytes are buffered in a small FIFO and each one is sent
// as an 8-bit SFD followed by the data byte, both LSB first, one bit per clk.
module transmitter #(
    parameter logic [7:0] SFD     = 8'hAB,
    parameter int         FIFO_AW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       din,
    input  logic             wr_en,
    output logic             full,
    output logic [FIFO_AW:0] count,
    output logic             tx,
    output logic             busy,
    output logic             tx_done
);
    localparam int               DEPTH   = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SFD, ST_DATA} state_t;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, wptr_d;
    logic [FIFO_AW-1:0] rptr_q, rptr_d;
    logic [FIFO_AW:0]   count_q, count_d;

    state_t     state_q;
    logic [2:0] bitcnt_q;
    logic [2:0] bitcnt_inc;
    logic [7:0] data_q;
    logic       tx_q, busy_q, done_q;

    logic push, pop, nonEmpty, lastBit;

    assign full       = (count_q == DEPTH_C);
    assign nonEmpty   = (count_q != '0);
    assign lastBit    = (bitcnt_q == 3'd7);
    assign bitcnt_inc = bitcnt_q + 3'd1;
    assign push       = wr_en && !full;
    // The head is consumed at frame start, so the byte on the line is no longer counted.
    assign pop        = nonEmpty && ((state_q == ST_IDLE) || ((state_q == ST_DATA) && lastBit));

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            data_q   <= 8'h00;
            tx_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    tx_q     <= 1'b0;
                    busy_q   <= 1'b0;
                    bitcnt_q <= 3'd0;
                    if (nonEmpty) begin
                        data_q  <= mem_q[rptr_q];
                        state_q <= ST_SFD;
                        tx_q    <= SFD[0];
                        busy_q  <= 1'b1;
                    end
                end
                ST_SFD: begin
                    if (lastBit) begin
                        state_q  <= ST_DATA;
                        tx_q     <= data_q[0];
                        bitcnt_q <= 3'd0;
                    end else begin
                        tx_q     <= SFD[bitcnt_inc];
                        bitcnt_q <= bitcnt_inc;
                    end
                end
                ST_DATA: begin
                    if (lastBit) begin
                        bitcnt_q <= 3'd0;
                        // Chain straight into the next frame so the stream has no idle gap.
                        if (nonEmpty) begin
                            data_q  <= mem_q[rptr_q];
                            state_q <= ST_SFD;
                            tx_q    <= SFD[0];
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tx_q     <= data_q[bitcnt_inc];
                        bitcnt_q <= bitcnt_inc;
                        done_q   <= (bitcnt_q == 3'd6);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count   = count_q;
    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
endmodule
